// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//
// Run-time coefficient reload controller for the single-precision FIR engine.
// A load request stalls the sample sequencer at the next sample boundary.
// The loader then accepts a coefficient burst over a valid/ready stream and
// writes each beat into the coefficient port of the filter memory. When the
// burst is finished it releases the stall and reports the outcome.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rst_i           asynchronous active-high reset
//   ce_i            clock enable; state, counter and handshakes freeze when low
//   load_start_i    single-cycle request for a coefficient reload
//   filter_busy_i   sequencer is mid-sample; the loader waits for it to clear
//   coef_i          coefficient data (IEEE-754 single)
//   coef_valid_i    coef_i is valid
//   coef_last_i     final beat of the burst
//   coef_ready_o    loader accepts a beat (high exactly in LOAD / FLUSH)
//   hold_o          stall to the sequencer; no new sample starts while high
//   en_h_o          coefficient port enable (single-cycle pulse per write)
//   we_h_o          coefficient port write enable (single-cycle pulse)
//   addr_h_o        coefficient write address
//   h_o             coefficient write data
//   done_o          one-cycle pulse at the end of every load, good or bad
//   err_o           last load had the wrong burst length; sticky until the
//                   next load request
//   coeffs_valid_o  a complete, error-free coefficient set is resident
// -----------------------------------------------------------------------------
module fir_coeff_loader #(
  parameter int SP_WIDTH      = 32,
  parameter int FILTER_ORDER  = 4,
  parameter int MEMORY_DEPTH  = 2 * FILTER_ORDER,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH),
  parameter int COEFF_BASE    = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ce_i,
  input  logic                     load_start_i,
  input  logic                     filter_busy_i,
  input  logic [SP_WIDTH-1:0]      coef_i,
  input  logic                     coef_valid_i,
  input  logic                     coef_last_i,
  output logic                     coef_ready_o,
  output logic                     hold_o,
  output logic                     en_h_o,
  output logic                     we_h_o,
  output logic [ADDRESS_WIDTH-1:0] addr_h_o,
  output logic [SP_WIDTH-1:0]      h_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     coeffs_valid_o
);

  // The coefficient window must fit inside the filter memory.
  if (COEFF_BASE + FILTER_ORDER > MEMORY_DEPTH) begin : g_bad_coeff_window
    $error("fir_coeff_loader: COEFF_BASE + FILTER_ORDER exceeds MEMORY_DEPTH");
  end

  // The counter must be able to reach FILTER_ORDER after the final good beat.
  localparam int COUNT_WIDTH = $clog2(FILTER_ORDER + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(FILTER_ORDER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_ready;
  logic                     r_hold;
  logic                     r_done;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [SP_WIDTH-1:0]      r_data;
  logic                     r_err;
  logic                     r_coeffs_valid;

  logic                     w_accept;
  logic                     w_start;
  logic                     w_write;
  logic                     w_set_err;

  // r_ready is high exactly while in LOAD/FLUSH, so this is the handshake.
  assign w_accept = coef_valid_i & r_ready & ce_i;

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned; a missing default here would infer a latch.
    w_state_next = r_state;
    w_start      = 1'b0;
    w_write      = 1'b0;
    w_set_err    = 1'b0;

    if (ce_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (load_start_i) begin
            w_state_next = S_WAIT_IDLE;
            w_start      = 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (!filter_busy_i) w_state_next = S_LOAD;
        end

        S_LOAD: begin
          if (w_accept) begin
            w_write = 1'b1;
            if (coef_last_i) begin
              // Short burst ends early; the beats already written stay.
              w_state_next = S_DONE;
              w_set_err    = (r_count != LAST_INDEX);
            end else if (r_count == LAST_INDEX) begin
              // Full set written but no last flag: drain the rest unwritten.
              w_state_next = S_FLUSH;
              w_set_err    = 1'b1;
            end
          end
        end

        S_FLUSH: begin
          if (w_accept && coef_last_i) w_state_next = S_DONE;
        end

        S_DONE: begin
          w_state_next = S_IDLE;
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, control outputs and write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the write address/data registers are reset as well (there is
      // no storage array here), because every output must read 0 in reset.
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_ready        <= 1'b0;
      r_hold         <= 1'b0;
      r_done         <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_err          <= 1'b0;
      r_coeffs_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_next;

      // Registered decodes of the state being entered, so they line up
      // exactly with the state itself.
      r_hold  <= (w_state_next != S_IDLE);
      r_ready <= (w_state_next == S_LOAD) || (w_state_next == S_FLUSH);
      // Pulse only on entry, so a frozen ce_i in DONE cannot stretch it.
      r_done  <= (w_state_next == S_DONE) && (r_state != S_DONE);

      // Write strobe follows w_write every cycle, independent of ce_i, so a
      // write is never repeated while the enable is low.
      r_we <= w_write;
      if (w_write) begin
        r_addr <= ADDRESS_WIDTH'(COEFF_BASE) + ADDRESS_WIDTH'(r_count);
        r_data <= coef_i;
      end

      if (w_start) begin
        r_count        <= '0;
        r_err          <= 1'b0;
        r_coeffs_valid <= 1'b0;
      end else begin
        if (w_write) r_count <= r_count + 1'b1;
        if (w_set_err) r_err <= 1'b1;
        // The final write is issued during DONE, so the set is declared
        // resident only as DONE is left.
        if (ce_i && r_state == S_DONE) r_coeffs_valid <= ~r_err;
      end
    end
  end

  assign coef_ready_o   = r_ready;
  assign hold_o         = r_hold;
  assign en_h_o         = r_we;
  assign we_h_o         = r_we;
  assign addr_h_o       = r_addr;
  assign h_o            = r_data;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign coeffs_valid_o = r_coeffs_valid;

endmodule
